// File: rtl/csa_pipe_adder.sv
// Pipelined carry-skip adder: one BLOCK-bit ripple/skip block per stage, with a valid/ready handshake.
// Operands are skewed forward and sum slices deskewed so the last stage holds the complete result.
module csa_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout,
  output logic                     ovf,
  output logic [WIDTH/BLOCK-1:0]   skip_mask
);

  localparam int NB   = WIDTH / BLOCK;
  localparam int LAST = NB - 1;

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : gBadParams
    $error("csa_pipe_adder: WIDTH must be a positive multiple of BLOCK");
  end

  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < NB; k++) begin : gStage
    // Stage k still carries the operand bits of blocks k..NB-1.
    localparam int IW = WIDTH - k * BLOCK;

    logic [IW-1:0]          aIn;
    logic [IW-1:0]          bIn;
    logic                   cIn;
    logic                   vIn;
    logic [BLOCK-1:0]       p;
    logic [BLOCK-1:0]       s;
    logic [BLOCK:0]         c;
    logic                   z;
    logic                   cOut;
    logic [(k+1)*BLOCK-1:0] sum_d;
    logic [(k+1)*BLOCK-1:0] sum_q;
    logic [k:0]             skip_d;
    logic [k:0]             skip_q;
    logic                   valid_q;
    logic                   carry_q;

    if (k == 0) begin : gFirst
      assign aIn    = a;
      assign bIn    = b;
      assign cIn    = cin;
      assign vIn    = in_valid;
      assign sum_d  = s;
      assign skip_d = z;
    end else begin : gNext
      assign aIn    = gStage[k-1].gFwd.a_q;
      assign bIn    = gStage[k-1].gFwd.b_q;
      assign cIn    = gStage[k-1].carry_q;
      assign vIn    = gStage[k-1].valid_q;
      assign sum_d  = {s, gStage[k-1].sum_q};
      assign skip_d = {z, gStage[k-1].skip_q};
    end

    always_comb begin
      p    = aIn[BLOCK-1:0] ^ bIn[BLOCK-1:0];
      c    = '0;
      c[0] = cIn;
      for (int i = 0; i < BLOCK; i++) begin
        c[i+1] = (aIn[i] & bIn[i]) | (p[i] & c[i]);
      end
      s    = p ^ c[BLOCK-1:0];
      z    = &p;
      cOut = z ? cIn : c[BLOCK];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
        skip_q  <= '0;
      end else if (!stall) begin
        valid_q <= vIn;
        carry_q <= cOut;
        sum_q   <= sum_d;
        skip_q  <= skip_d;
      end
    end

    if (k < LAST) begin : gFwd
      logic [IW-BLOCK-1:0] a_q;
      logic [IW-BLOCK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!stall) begin
          a_q <= aIn[IW-1:BLOCK];
          b_q <= bIn[IW-1:BLOCK];
        end
      end
    end else begin : gLast
      // Here aIn/bIn hold only the top block, so bit BLOCK-1 is the original operand MSB.
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= (aIn[BLOCK-1] == bIn[BLOCK-1]) && (s[BLOCK-1] != aIn[BLOCK-1]);
        end
      end
    end
  end

  assign out_valid = gStage[LAST].valid_q;
  assign sum       = gStage[LAST].sum_q;
  assign cout      = gStage[LAST].carry_q;
  assign skip_mask = gStage[LAST].skip_q;
  assign ovf       = gStage[LAST].gLast.ovf_q;

endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined carry-skip adder: WIDTH-bit operands split into BLOCK-bit carry-skip blocks, with one pipeline stage per block and a valid/ready handshake on both sides. Each block uses ripple carry internally and bypasses its carry-in through a skip mux when all of its propagate bits are set. This is the wide, clocked successor to the fixed 8-bit two-block combinational carry-skip adder. It sits in datapaths that need wide adds at full clock rate and tolerate NB cycles of latency. It also reports a per-block skip mask for coverage and debug, plus signed overflow.

## Interface
- WIDTH, 32: operand/sum width; must be a multiple of BLOCK and at least BLOCK.
- BLOCK, 4: bits per carry-skip block; NB = WIDTH/BLOCK stages.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; one clock; synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  adder can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to block 0.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  a + b + cin, low WIDTH bits.
- cout  out  1  carry out of block NB-1.
- ovf  out  1  signed overflow: (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
- skip_mask  out  NB  bit k set iff block k had all propagate bits set, so its carry-out was taken from its carry-in.

## Operation
- Stage k (0..NB-1) computes block k: p = a_k ^ b_k; ripple carries; s_k = a_k ^ b_k ^ c; z = &p; carry_out = z ? carry_in : ripple_out.
- Carry-in for stage 0 is cin; for stage k>0 it is the registered carry-out of stage k-1.
- Skew registers: operand slices of blocks k..NB-1 travel forward with the beat.
- Deskew registers: sum slices of completed blocks travel forward with the beat. The stage NB-1 register drives sum/cout/ovf/skip_mask.
- ovf uses the original a/b MSBs, carried in the skew path.
- Each stage has a valid bit. Bubbles propagate and do not corrupt neighbouring beats.
- Global stall: stall = out_valid && !out_ready. in_ready = !stall. When stall is high, no stage register (data or valid) changes.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- When not stalled, each stage loads from its predecessor. Stage 0 loads valid = in_valid and data = block-0 result of a/b/cin.
- Outputs are held stable while out_valid && !out_ready.
- Reset: all valid bits 0. sum, cout, ovf, skip_mask = 0. out_valid = 0. in_ready = 1 the cycle after reset.
- Reset mid-operation discards all in-flight beats and produces no partial outputs.
- Elaboration must fail (generate error) if WIDTH % BLOCK != 0 or BLOCK < 1.

## Timing
- Latency: a beat accepted at rising edge t has out_valid high after edge t+NB-1, provided no stall occurs. For NB=1, the result is valid the cycle after acceptance.
- Each stall cycle adds one cycle to latency for every beat in flight.
- Throughput: one beat per clock while out_ready is high.
- in_ready depends combinationally on out_ready. There is no other combinational input-to-output path.
- Critical path per stage: BLOCK-bit ripple plus one skip mux. Stages do not chain combinationally.
- in_valid && !in_ready: the beat is not taken. The source must hold it.
- Simultaneous in- and out-transfer in the same cycle is legal and keeps the pipe full.

## Test plan
- WIDTH=8, BLOCK=4: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0, skip_mask=2'b11, out_valid 2 cycles after acceptance.
- WIDTH=8, BLOCK=4: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1, skip_mask=2'b00. Also a=0x0F, b=0x10, cin=0 -> sum=0x1F, skip_mask=2'b01.
- WIDTH=32, BLOCK=4: stream 100 random beats back-to-back with out_ready=1 -> results match a+b+cin in order, one per cycle, first out_valid after 8 cycles.
- Backpressure: random out_ready (50% duty) over 200 beats -> no loss or duplication, and outputs stable while stalled; in_ready equals !(out_valid && !out_ready) every cycle.
- Reset with 4 beats in flight (WIDTH=32, BLOCK=8) -> out_valid=0 and all outputs 0 next cycle; no stale beat emerges afterwards.
- Corner sweep, WIDTH=16, BLOCK=4: a=0xFFFF with b=0, cin∈{0,1}; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1; exhaustive a,b at WIDTH=4, BLOCK=4 against a reference sum.
